// File: rtl/mod_12_down_counter.sv
// -----------------------------------------------------------------------------
// mod_12_down_counter
//   Loadable modulo-MOD down counter (default MOD=12): counts MOD-1 .. 0 and
//   wraps while enabled. Companion of the mod-12 up counter (same load/d_in/
//   c_out interface), adding a count enable, a terminal-count flag, a
//   registered borrow pulse for cascading and a load-range error pulse.
//
//   Build option: MOD12_DOWN_AUTORELOAD_EN
//     defined   -> a preset register captures every (clamped) loaded value
//                  (reset value MOD-1); the counter wraps to the preset, giving
//                  a programmable period of preset+1 counts.
//     undefined -> the wrap value is always MOD-1; load only sets the count.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous reset, active-low
//   d_in      in   WIDTH  parallel load value
//   load      in   1      synchronous parallel load (priority over en)
//   en        in   1      count enable, decrement by 1 per enabled cycle
//   c_out     out  WIDTH  current count, registered, always in 0..MOD-1
//   tc        out  1      terminal count, combinational: (c_out==0) && en
//   borrow    out  1      1-cycle pulse aligned with the wrap update
//   load_err  out  1      1-cycle pulse aligned with an out-of-range load
// -----------------------------------------------------------------------------
module mod_12_down_counter #(
    parameter int unsigned MOD   = 12,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_in,
    input  logic             load,
    input  logic             en,
    output logic [WIDTH-1:0] c_out,
    output logic             tc,
    output logic             borrow,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

    logic             load_oor;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] wrap_val;

    // Out-of-range loads are clamped to the top count so c_out stays legal.
    assign load_oor = (d_in > MAX_VAL);
    assign load_val = load_oor ? MAX_VAL : d_in;

`ifdef MOD12_DOWN_AUTORELOAD_EN
    logic [WIDTH-1:0] preset;

    always_ff @(posedge clk) begin
        if (!rst) begin
            preset <= MAX_VAL;
        end else if (load) begin
            preset <= load_val;
        end
    end

    assign wrap_val = preset;
`else
    assign wrap_val = MAX_VAL;
`endif

    // Combinational so a cascaded stage using en_next = tc steps on the same
    // edge as this stage wraps.
    assign tc = (c_out == '0) && en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            c_out    <= '0;
            borrow   <= 1'b0;
            load_err <= 1'b0;
        end else if (load) begin
            c_out    <= load_val;
            load_err <= load_oor;
            borrow   <= 1'b0;
        end else if (en) begin
            load_err <= 1'b0;
            if (c_out == '0) begin
                c_out  <= wrap_val;
                borrow <= 1'b1;
            end else begin
                c_out  <= c_out - 1'b1;
                borrow <= 1'b0;
            end
        end else begin
            borrow   <= 1'b0;
            load_err <= 1'b0;
        end
    end

endmodule
